// File: rtl/stg_ia_if.sv
// stg_ia_if: sequential-PC fetch into a DEPTH-entry prefetch FIFO presenting {pc, instr}; issue-to-valid 2 edges, 1/cycle steady state.
// Stall holds the head and throttles issue on FIFO+in-flight occupancy; branch flushes all. Optional counters: STG_IA_IF_PERF_EN.
module stg_ia_if #(
    parameter int WIDTH      = 24,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4,
    parameter int RESET_PC   = 0
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst,
    input  logic                  iw_stall,
    input  logic                  iw_branch_taken,
    input  logic [ADDR_WIDTH-1:0] iw_branch_pc,
    output logic                  or_imem_en,
    output logic [ADDR_WIDTH-1:0] or_imem_addr,
    input  logic [WIDTH-1:0]      iw_imem_rdata,
    output logic                  or_ifid_valid,
    output logic [ADDR_WIDTH-1:0] or_ifid_pc,
    output logic [WIDTH-1:0]      or_ifid_instr
`ifdef STG_IA_IF_PERF_EN
    ,
    output logic [15:0]           or_fetch_cnt,
    output logic [15:0]           or_flush_cnt
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;
    localparam logic [ADDR_WIDTH-1:0] PC0 = ADDR_WIDTH'(RESET_PC);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [WIDTH-1:0]      instr;
    } entry_t;

    typedef struct packed {
        logic                  vld;
        logic [ADDR_WIDTH-1:0] pc;
    } tag_t;

    entry_t                mem [DEPTH];
    entry_t                head;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    tag_t                  tag_iss;
    tag_t                  tag_bus;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [OW-1:0]         occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head          = mem[rd_ptr];
    assign or_ifid_valid = (count != '0);
    assign or_ifid_pc    = or_ifid_valid ? head.pc : '0;
    assign or_ifid_instr = or_ifid_valid ? head.instr : '0;

    // Occupancy counts words already requested, so the FIFO can never overflow.
    always_comb begin
        pop   = or_ifid_valid & ~iw_stall;
        push  = tag_bus.vld;
        occ   = OW'(count) + OW'(tag_iss.vld) + OW'(tag_bus.vld) - OW'(pop);
        issue = (occ < OW'(DEPTH));
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_pc         <= PC0;
            or_imem_en   <= 1'b0;
            or_imem_addr <= PC0;
            tag_iss      <= '0;
            tag_bus      <= '0;
        end else if (iw_branch_taken) begin
            r_pc         <= iw_branch_pc + ADDR_WIDTH'(1);
            or_imem_en   <= 1'b1;
            or_imem_addr <= iw_branch_pc;
            tag_iss.vld  <= 1'b1;
            tag_iss.pc   <= iw_branch_pc;
            tag_bus      <= '0;
        end else begin
            tag_bus <= tag_iss;
            if (issue) begin
                r_pc         <= r_pc + ADDR_WIDTH'(1);
                or_imem_en   <= 1'b1;
                or_imem_addr <= r_pc;
                tag_iss.vld  <= 1'b1;
                tag_iss.pc   <= r_pc;
            end else begin
                or_imem_en  <= 1'b0;
                tag_iss.vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (iw_branch_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge iw_clk) begin
        if (push && !iw_branch_taken) begin
            mem[wr_ptr].pc    <= tag_bus.pc;
            mem[wr_ptr].instr <= iw_imem_rdata;
        end
    end

`ifdef STG_IA_IF_PERF_EN
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            or_fetch_cnt <= '0;
            or_flush_cnt <= '0;
        end else begin
            if (pop) or_fetch_cnt <= or_fetch_cnt + 16'd1;
            if (iw_branch_taken && (or_ifid_valid || tag_iss.vld || tag_bus.vld))
                or_flush_cnt <= or_flush_cnt + 16'd1;
        end
    end
`endif

    a_count_bound: assert property (@(posedge iw_clk) disable iff (iw_rst) count <= CW'(DEPTH));

endmodule

// File: tb/tb_stg_ia_if.sv
// Randomized bench for stg_ia_if: expected fetch stream queued by the stimulus side, checked by an independent monitor.
`timescale 1ns/1ps
module tb_stg_ia_if;
    localparam int WIDTH    = 24;
    localparam int AW       = 12;
    localparam int DEPTH    = 4;
    localparam int RESET_PC = 0;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           stall = 1'b0;
    logic           br = 1'b0;
    logic [AW-1:0]  bpc = '0;
    logic           imem_en;
    logic [AW-1:0]  imem_addr;
    logic [WIDTH-1:0] imem_rdata = '0;
    logic           v;
    logic [AW-1:0]  opc;
    logic [WIDTH-1:0] oinstr;
`ifdef STG_IA_IF_PERF_EN
    logic [15:0]    fetch_cnt;
    logic [15:0]    flush_cnt;
`endif

    stg_ia_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .iw_clk(clk), .iw_rst(rst), .iw_stall(stall),
        .iw_branch_taken(br), .iw_branch_pc(bpc),
        .or_imem_en(imem_en), .or_imem_addr(imem_addr), .iw_imem_rdata(imem_rdata),
        .or_ifid_valid(v), .or_ifid_pc(opc), .or_ifid_instr(oinstr)
`ifdef STG_IA_IF_PERF_EN
        , .or_fetch_cnt(fetch_cnt), .or_flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] imem [1<<AW];
    initial for (int i = 0; i < (1 << AW); i++) imem[i] = WIDTH'(32'h100 + i);

    // Synchronous imem; garbage on idle cycles so stray captures show up.
    always @(posedge clk) imem_rdata <= imem_en ? imem[imem_addr] : WIDTH'($urandom);

    typedef struct {
        logic [AW-1:0]    pc;
        logic [WIDTH-1:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   next_pc = RESET_PC;
    int   compared = 0;
    int   mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic reseed(input int target);
        exp_q.delete();
        next_pc = target;
    endtask

    task automatic topup();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc    = AW'(next_pc);
            e.instr = imem[next_pc];
            exp_q.push_back(e);
            next_pc = (next_pc + 1) % (1 << AW);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply(input logic st, input logic b, input logic [AW-1:0] t);
        stall = st;
        br    = b;
        bpc   = t;
        if (b) reseed(int'(t));
        topup();
    endtask

    task automatic wait_head(input logic [AW-1:0] target);
        int n = 0;
        while (!(v && opc == target) && n < 40) begin
            tick();
            apply(1'b0, 1'b0, '0);
            n++;
        end
        compared++;
        if (!(v && opc == target)) begin
            mismatched++;
            $display("FAIL wait_head: head pc %0h never reached, last pc %0h valid %0b", target, opc, v);
        end
    endtask

    task automatic branch_check(input logic st, input logic [AW-1:0] t);
        apply(st, 1'b1, t);
        tick(); apply(1'b0, 1'b0, '0);
        check("flush_valid_e0", 32'(v), 32'd0);
        tick(); apply(1'b0, 1'b0, '0);
        check("flush_valid_e1", 32'(v), 32'd0);
        tick(); apply(1'b0, 1'b0, '0);
        check("flush_valid_e2", 32'(v), 32'd1);
        check("flush_target_pc", 32'(opc), 32'(t));
        check("flush_target_instr", 32'(oinstr), 32'h100 + 32'(t));
    endtask

    // Monitor: timing rules plus in-order scoreboard of accepted entries.
    int             k = 0;
    logic [AW-1:0]  tgt = AW'(RESET_PC);
    logic           p_hold = 1'b0;
    logic [AW-1:0]  p_pc = '0;
    logic [WIDTH-1:0] p_in = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_valid", 32'(v), 32'd0);
                check("rst_en", 32'(imem_en), 32'd0);
                check("rst_addr", 32'(imem_addr), 32'(RESET_PC));
                check("rst_pc", 32'(opc), 32'd0);
                check("rst_instr", 32'(oinstr), 32'd0);
`ifdef STG_IA_IF_PERF_EN
                check("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
                check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
                k = 0;
                p_hold = 1'b0;
            end else begin
                check("valid_timing", 32'(v), (k >= 3) ? 32'd1 : 32'd0);
                if (k == 0) check("idle_en", 32'(imem_en), 32'd0);
                if (k == 1) begin
                    check("redirect_en", 32'(imem_en), 32'd1);
                    check("redirect_addr", 32'(imem_addr), 32'(tgt));
                end
                if (p_hold) begin
                    check("stall_hold_pc", 32'(opc), 32'(p_pc));
                    check("stall_hold_instr", 32'(oinstr), 32'(p_in));
                end
                if (v && !stall && !br) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL sb_underflow: pc %0h presented with nothing expected", opc);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pc", 32'(opc), 32'(e.pc));
                        check("sb_instr", 32'(oinstr), 32'(e.instr));
                    end
                end
                p_hold = v && stall && !br;
                p_pc   = opc;
                p_in   = oinstr;
                if (br) begin
                    k = 1;
                    tgt = bpc;
                end else if (k == 0) begin
                    k = 1;
                    tgt = AW'(RESET_PC);
                end else if (k < 3) begin
                    k++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reseed(RESET_PC);
        topup();
        repeat (3) tick();
        rst = 1'b0;

        // Straight-line, then stall with head at 0x003.
        wait_head(12'h003);
        apply(1'b1, 1'b0, '0);
        repeat (5) begin tick(); apply(1'b1, 1'b0, '0); end
        tick();
        check("stall_en_drop", 32'(imem_en), 32'd0);
        check("stall_head_pc", 32'(opc), 32'h003);
        check("stall_head_instr", 32'(oinstr), 32'h000103);
        apply(1'b0, 1'b0, '0);

        wait_head(12'h005);
        branch_check(1'b0, 12'h080);
        repeat (4) begin tick(); apply(1'b0, 1'b0, '0); end

        wait_head(12'h085);
        branch_check(1'b1, 12'h040);
        repeat (4) begin tick(); apply(1'b0, 1'b0, '0); end

        tick();
        branch_check(1'b0, 12'hFFE);
        repeat (6) begin tick(); apply(1'b0, 1'b0, '0); end

        for (int i = 0; i < 500; i++) begin
            tick();
            apply($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, AW'($urandom_range(0, (1 << AW) - 1)));
        end
        tick();
        apply(1'b0, 1'b0, '0);
        repeat (4) begin tick(); apply(1'b0, 1'b0, '0); end

        // Async reset between edges.
        tick();
        #1;
        rst = 1'b1;
        reseed(RESET_PC);
        topup();
        #1;
        check("async_valid", 32'(v), 32'd0);
        check("async_en", 32'(imem_en), 32'd0);
`ifdef STG_IA_IF_PERF_EN
        check("async_fetch_cnt", 32'(fetch_cnt), 32'd0);
        check("async_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
        repeat (2) tick();
        rst = 1'b0;
        repeat (12) begin tick(); apply(1'b0, 1'b0, '0); end
        check("refetch_valid", 32'(v), 32'd1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
